// File: rtl/clock_display.sv
// clock_display
//   Captures the binary hour/min/sec fields from the timekeeping block and
//   converts each one to two BCD digits with a subtract-by-ten FSM. The six
//   digits (HH MM SS) are then scanned onto a shared active-low 7-segment bus.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | watch inputs against the captured copy, latch on change
//   CONV_H | split the captured hour into tens/units
//   CONV_M | split the captured minute into tens/units
//   CONV_S | split the captured second into tens/units
//   COMMIT | load all display digits and err in one cycle
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   enable         1 = scan runs, 0 = scan frozen and all digits dark
//   hour/min/sec   binary time fields (0..23 / 0..59 / 0..59)
//   seg, dp        active-low segments {g..a} and decimal point
//   digit_en       active-low one-hot strobe, bit 5 = hour tens
//   err            high while the range-error pattern is displayed
module clock_display #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LEAD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] digit_en,
    output logic       err
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [2:0] {IDLE, CONV_H, CONV_M, CONV_S, COMMIT} state_t;
    state_t state, state_nx;

    logic [4:0] cap_hour;
    logic [5:0] cap_min, cap_sec;
    logic [5:0] rem;
    logic [3:0] tens_h, tens_m, tens_s;
    logic [3:0] unit_h, unit_m, unit_s;
    logic       err_pend;
    logic [3:0] disp_ht, disp_hu, disp_mt, disp_mu, disp_st, disp_su;
    logic       disp_err;
    logic       in_change, in_range, rem_ge10;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic [6:0]    seg_digit, seg_nx;
    logic          dp_nx, blank_lead;

    assign in_change = {hour, min, sec} != {cap_hour, cap_min, cap_sec};
    assign in_range  = (hour <= 5'd23) && (min <= 6'd59) && (sec <= 6'd59);
    assign rem_ge10  = rem >= 6'd10;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_change) state_nx = in_range ? CONV_H : COMMIT;
            CONV_H:  if (!rem_ge10) state_nx = CONV_M;
            CONV_M:  if (!rem_ge10) state_nx = CONV_S;
            CONV_S:  if (!rem_ge10) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Conversion datapath. Display digits only change in COMMIT, so the
    // scanned time is never a mix of old and new fields. An out-of-range
    // capture leaves the old digits in place behind the error pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_hour <= '0;
            cap_min  <= '0;
            cap_sec  <= '0;
            rem      <= '0;
            tens_h   <= '0;
            tens_m   <= '0;
            tens_s   <= '0;
            unit_h   <= '0;
            unit_m   <= '0;
            unit_s   <= '0;
            err_pend <= 1'b0;
            disp_ht  <= '0;
            disp_hu  <= '0;
            disp_mt  <= '0;
            disp_mu  <= '0;
            disp_st  <= '0;
            disp_su  <= '0;
            disp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_change) begin
                        cap_hour <= hour;
                        cap_min  <= min;
                        cap_sec  <= sec;
                        err_pend <= !in_range;
                        rem      <= {1'b0, hour};
                        tens_h   <= '0;
                        tens_m   <= '0;
                        tens_s   <= '0;
                    end
                end
                CONV_H: begin
                    if (rem_ge10) begin
                        rem    <= rem - 6'd10;
                        tens_h <= tens_h + 4'd1;
                    end else begin
                        unit_h <= rem[3:0];
                        rem    <= cap_min;
                    end
                end
                CONV_M: begin
                    if (rem_ge10) begin
                        rem    <= rem - 6'd10;
                        tens_m <= tens_m + 4'd1;
                    end else begin
                        unit_m <= rem[3:0];
                        rem    <= cap_sec;
                    end
                end
                CONV_S: begin
                    if (rem_ge10) begin
                        rem    <= rem - 6'd10;
                        tens_s <= tens_s + 4'd1;
                    end else begin
                        unit_s <= rem[3:0];
                    end
                end
                COMMIT: begin
                    if (!err_pend) begin
                        disp_ht <= tens_h;
                        disp_hu <= unit_h;
                        disp_mt <= tens_m;
                        disp_mu <= unit_m;
                        disp_st <= tens_s;
                        disp_su <= unit_s;
                    end
                    disp_err <= err_pend;
                end
                default: ;
            endcase
        end
    end

    // Scan: prescaler and index freeze while disabled so scanning resumes
    // exactly where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= 3'd5;
        end else if (enable) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == 3'd0) ? 3'd5 : idx - 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd5:    digit = disp_ht;
            3'd4:    digit = disp_hu;
            3'd3:    digit = disp_mt;
            3'd2:    digit = disp_mu;
            3'd1:    digit = disp_st;
            3'd0:    digit = disp_su;
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        seg_digit = 7'h7F;
        case (digit)
            4'd0:    seg_digit = 7'h40;
            4'd1:    seg_digit = 7'h79;
            4'd2:    seg_digit = 7'h24;
            4'd3:    seg_digit = 7'h30;
            4'd4:    seg_digit = 7'h19;
            4'd5:    seg_digit = 7'h12;
            4'd6:    seg_digit = 7'h02;
            4'd7:    seg_digit = 7'h78;
            4'd8:    seg_digit = 7'h00;
            4'd9:    seg_digit = 7'h10;
            default: seg_digit = 7'h7F;
        endcase
    end

    assign blank_lead = (BLANK_LEAD != 0) && (idx == 3'd5) && (disp_ht == 4'd0);

    always_comb begin
        seg_nx = seg_digit;
        if (disp_err)        seg_nx = 7'h3F;
        else if (blank_lead) seg_nx = 7'h7F;
        // Separator dots blink with the seconds: lit on even seconds.
        dp_nx = !(!disp_err && ((idx == 3'd4) || (idx == 3'd2)) && !disp_su[0]);
    end

    // err is registered alongside seg so it tracks the pattern on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg      <= 7'h7F;
            dp       <= 1'b1;
            digit_en <= 6'h3F;
            err      <= 1'b0;
        end else begin
            err <= disp_err;
            if (enable) begin
                seg      <= seg_nx;
                dp       <= dp_nx;
                digit_en <= ~(6'd1 << idx);
            end else begin
                seg      <= 7'h7F;
                dp       <= 1'b1;
                digit_en <= 6'h3F;
            end
        end
    end

endmodule

// File: tb/tb_clock_display.sv
// Bench for clock_display. A reference model on the rising edge works from
// whole-number time values: it predicts when a captured time reaches the
// display (from the tens digits of each field) and which digit the scan
// selects (from the count of enabled cycles). Each cycle it queues the
// expected output word; a monitor on the falling edge pops and compares.
module tb_clock_display;

    localparam int SD = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b1;
    logic [4:0] hour   = 5'd0;
    logic [5:0] min    = 6'd0;
    logic [5:0] sec    = 6'd0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] digit_en;
    logic       err;

    clock_display #(.SCAN_DIV(SD), .BLANK_LEAD(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] en;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "reset";

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // model state
    int m_cyc = 0;
    int cap_h = 0, cap_m = 0, cap_s = 0;
    int free_at = 0;
    bit pend = 0;
    int pend_at = 0, pend_h = 0, pend_m = 0, pend_s = 0;
    bit pend_err = 0;
    int d_h = 0, d_m = 0, d_s = 0;
    bit d_err = 0;
    int n_en = 0;

    function automatic exp_t predict();
        exp_t e;
        int   idx;
        int   digs[6];
        e.err = d_err;
        if (!enable) begin
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.en  = 6'h3F;
            return e;
        end
        idx = 5 - ((n_en / SD) % 6);
        digs[0] = d_s % 10;
        digs[1] = d_s / 10;
        digs[2] = d_m % 10;
        digs[3] = d_m / 10;
        digs[4] = d_h % 10;
        digs[5] = d_h / 10;
        e.en = ~(6'd1 << idx);
        if (d_err)                      e.seg = 7'h3F;
        else if (idx == 5 && d_h < 10)  e.seg = 7'h7F;
        else                            e.seg = seg_tab[digs[idx]];
        e.dp = (!d_err && (idx == 4 || idx == 2) && (d_s % 2 == 0)) ? 1'b0 : 1'b1;
        return e;
    endfunction

    initial begin : model
        exp_t e;
        int   h, m, s, t;
        bit   bad;
        forever begin
            @(posedge clk);
            h = int'(hour);
            m = int'(min);
            s = int'(sec);
            if (reset) e = '{seg: 7'h7F, dp: 1'b1, en: 6'h3F, err: 1'b0};
            else       e = predict();
            exp_q.push_back(e);
            if (reset) begin
                cap_h = 0; cap_m = 0; cap_s = 0;
                free_at = m_cyc + 1;
                pend = 0;
                d_h = 0; d_m = 0; d_s = 0; d_err = 0;
                n_en = 0;
            end else begin
                if (pend && pend_at == m_cyc) begin
                    if (!pend_err) begin
                        d_h = pend_h; d_m = pend_m; d_s = pend_s;
                    end
                    d_err = pend_err;
                    pend  = 0;
                end
                if (m_cyc >= free_at && (h != cap_h || m != cap_m || s != cap_s)) begin
                    cap_h = h; cap_m = m; cap_s = s;
                    bad = (h > 23) || (m > 59) || (s > 59);
                    // idle detect + one cycle per tens step plus one per field + commit
                    t = bad ? 2 : (h / 10) + (m / 10) + (s / 10) + 5;
                    pend     = 1;
                    pend_at  = m_cyc + t - 1;
                    pend_h   = h; pend_m = m; pend_s = s;
                    pend_err = bad;
                    free_at  = m_cyc + t;
                end
                if (enable) n_en++;
            end
            m_cyc++;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({seg, dp, digit_en, err} !== e) begin
                    n_bad++;
                    $display("FAIL scan_out[%s] t=%0t: got seg=%h dp=%b en=%h err=%b, want seg=%h dp=%b en=%h err=%b",
                             phase, $time, seg, dp, digit_en, err, e.seg, e.dp, e.en, e.err);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%s] t=%0t: got %h, want %h", name, phase, $time, got, want);
        end
    endtask

    task automatic check_disp(input int ht, input int hu, input int mt,
                              input int mu, input int st, input int su);
        check_val("disp_ht", 8'(dut.disp_ht), 8'(ht));
        check_val("disp_hu", 8'(dut.disp_hu), 8'(hu));
        check_val("disp_mt", 8'(dut.disp_mt), 8'(mt));
        check_val("disp_mu", 8'(dut.disp_mu), 8'(mu));
        check_val("disp_st", 8'(dut.disp_st), 8'(st));
        check_val("disp_su", 8'(dut.disp_su), 8'(su));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_t(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour = h;
        min  = m;
        sec  = s;
    endtask

    initial begin : stim
        tick(3);
        check_val("reset_seg", 8'(seg), 8'h7F);
        check_val("reset_en", 8'(digit_en), 8'h3F);
        check_val("reset_dp", 8'(dp), 8'h01);
        check_val("reset_err", 8'(err), 8'h00);
        reset = 1'b0;
        phase = "after_reset";
        tick(30);

        phase = "max_time";
        set_t(5'd23, 6'd59, 6'd59);
        tick(40);
        check_disp(2, 3, 5, 9, 5, 9);

        phase = "atomic";
        set_t(5'd23, 6'd0, 6'd0);
        tick(40);

        phase = "out_of_range";
        set_t(5'd24, 6'd0, 6'd0);
        tick(30);
        check_val("err_set", 8'(err), 8'h01);
        phase = "err_clear";
        set_t(5'd12, 6'd0, 6'd0);
        tick(30);
        check_val("err_clr", 8'(err), 8'h00);
        check_disp(1, 2, 0, 0, 0, 0);

        phase = "change_in_conv";
        set_t(5'd10, 6'd10, 6'd10);
        tick(2);
        set_t(5'd11, 6'd10, 6'd10);
        tick(40);
        check_disp(1, 1, 1, 0, 1, 0);

        phase = "enable";
        tick(5);
        enable = 1'b0;
        tick(20);
        enable = 1'b1;
        tick(30);

        phase = "reset_mid_conv";
        set_t(5'd21, 6'd37, 6'd45);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(40);

        phase = "random";
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                hour = 5'($urandom_range(0, 31));
                min  = 6'($urandom_range(0, 63));
                sec  = 6'($urandom_range(0, 63));
            end else begin
                hour = 5'($urandom_range(0, 23));
                min  = 6'($urandom_range(0, 59));
                sec  = 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick($urandom_range(1, 25));
        end

        phase = "drain";
        enable = 1'b1;
        tick(40);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_display.md
Name: clock_display

Overview:
- Consumer of the time-of-day counter outputs (hour/min/sec, binary).
- Converts each field to two BCD digits with a sequential subtract-by-ten FSM.
- Time-multiplexes six digits, HH MM SS, onto a shared 7-segment bus with one-hot digit strobes.
- Sits between the timekeeping block and the board's 6-digit 7-segment display.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit is strobed; must be >= 2.
- BLANK_LEAD, 1: 1 blanks the hour-tens digit when it is 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  1 = scan runs; 0 = scan frozen and all digits off. Capture/convert is unaffected.
- hour  in  5  binary hours; valid 0..23.
- min  in  6  binary minutes; valid 0..59.
- sec  in  6  binary seconds; valid 0..59.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- digit_en  out  6  active-low one-hot; bit 5 = hour tens (leftmost), bit 0 = sec units.
- err  out  1  1 while the display shows the range-error pattern.

Behaviour:
- Reset values:
  - seg=7'h7F, dp=1, digit_en=6'h3F, err=0.
  - Captured inputs = 0; all six display BCD registers = 0; FSM=IDLE.
  - Prescaler = 0; digit index = 5.
- FSM states: IDLE, CONV_H, CONV_M, CONV_S, COMMIT.
- IDLE:
  - Each cycle, compare {hour,min,sec} with the captured copy.
  - On mismatch: latch inputs into the captured copy and range-check them.
  - All fields in range: clear the tens counters and go to CONV_H.
  - Any field out of range (hour>23, min>59 or sec>59): go to COMMIT with the error flag set.
- CONV_x (x = H, M, S):
  - While the working remainder >= 10: subtract 10 and increment tens, one step per cycle.
  - When remainder < 10: keep it as the units digit and advance to the next state.
  - A field with tens value t takes t+1 cycles.
- COMMIT (1 cycle):
  - Write all six display BCD registers and err atomically, then return to IDLE.
  - The displayed time is never a mix of old and new fields.
- Latency: with inputs changing at the edge before cycle k, display registers update at the edge ending cycle k + (tH+1)+(tM+1)+(tS+1)+1.
  - 00:00:00 takes 4 cycles; 23:59:59 takes 16.
  - Error path takes 2 cycles (IDLE detect, COMMIT).
- Input changes while not in IDLE are ignored. They are detected on the first IDLE cycle afterwards, because comparison is against the captured copy; no update is lost.
- Scan (only while enable=1):
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap, digit index decrements 5,4,..,0,5 (wrap-around).
- Registered outputs follow the digit index, one cycle after the index changes:
  - digit_en = ~(1<<index).
  - seg = 7-segment pattern of the selected BCD digit.
  - dp = 0 only on index 4 and 2 (HH.MM.SS separators), and only when units-of-seconds is even; else 1.
- BLANK_LEAD=1 and hour tens = 0: on index 5, seg=7'h7F and digit_en is still strobed.
- err=1: every digit shows seg=7'h3F (segment g only, a dash) and dp=1. err clears at the next valid COMMIT.
- enable=0:
  - Prescaler and index hold.
  - digit_en=6'h3F, seg=7'h7F, dp=1 from the next edge.
  - On re-enable, scanning resumes at the held index and prescaler value.
- Reset mid-conversion aborts the FSM. If the inputs are non-zero, they are re-captured after reset.
- Segment encoding (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10

Test Plan:
- Reset: hold reset 3 cycles with inputs 0 -> seg=7F, digit_en=3F, dp=1, err=0. With SCAN_DIV=4, after release: hour-tens blanked, then seg=40 on index 4..0 in order.
- Conversion latency: step inputs 0:0:0 -> 23:59:59 -> display regs read 2,3,5,9,5,9 exactly 16 cycles later. The index-0 strobe shows seg=10, and dp=1 because seconds are odd.
- Atomic update: change sec 59->0 and min 59->0 on the same edge while scanning -> no scan slot ever shows new seconds with old minutes.
- Out of range: hour=24 -> 2 cycles later err=1 and all digits seg=3F. Then 12:00:00 -> err=0 and the display shows 1,2,0,0,0,0.
- Change during conversion: apply 10:10:10, then 11:10:10 two cycles later -> after both conversions the display shows 1,1,1,0,1,0. Display regs show the 10:10:10 result in between.
- Enable: drop enable mid-scan -> next edge digit_en=3F. Raise it after 20 cycles -> the scan resumes at the same index with the remaining prescaler count.
